// File: rtl/pixel_mem_arbiter.sv
// rtl/pixel_mem_arbiter.sv - single-port frame buffer arbiter between video scanout and host writes
module pixel_mem_arbiter #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 4,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H),
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              resetn,
    input  logic              h_blank,
    input  logic              v_blank,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic              vblank_only,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    output logic              frame_start,
    input  logic              clear_stats,
    output logic [CNT_W-1:0]  wr_count_last,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_VIS = 2'd0,
        ST_HBL = 2'd1,
        ST_VBL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic              mode_latched;
    logic [CNT_W-1:0]  wr_cnt;
    logic [RD_LAT-1:0] rd_pipe;

    logic             vis;
    logic             allow;
    logic             accept;
    logic             stall;
    logic             prev_vblank;
    logic             v_rise;
    logic             v_fall;
    logic             scan_issued;
    logic [CNT_W-1:0] wr_cnt_next;

    // Host may only touch memory while scanout is idle; tear-free mode also excludes h-blank
    assign vis         = ~h_blank & ~v_blank;
    assign allow       = v_blank | (h_blank & ~mode_latched);
    assign wr_ready    = allow;
    assign accept      = wr_valid & allow;
    assign stall       = wr_valid & ~allow;

    // The FSM state doubles as the registered copy of v_blank used for edge detection
    assign prev_vblank = (state == ST_VBL);
    assign v_rise      = v_blank & ~prev_vblank;
    assign v_fall      = ~v_blank & prev_vblank;

    // A read in flight is an enabled, non-write memory cycle
    assign scan_issued = mem_en & ~mem_we;
    assign pix_valid   = rd_pipe[RD_LAT-1];
    assign pix_out     = pix_valid ? mem_rdata : '0;

    assign wr_cnt_next = (accept && (wr_cnt != CNT_MAX)) ? wr_cnt + CNT_W'(1) : wr_cnt;

    // Track video region, latch tear-free mode at the start of vertical blanking, flag frame start
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_VBL;
            mode_latched <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            if (v_blank) begin
                state <= ST_VBL;
            end else if (h_blank) begin
                state <= ST_HBL;
            end else begin
                state <= ST_VIS;
            end
            if (v_rise) begin
                mode_latched <= vblank_only;
            end
            frame_start <= v_fall;
        end
    end

    // Memory port arbitration: scanout first, then an allowed host write, else idle with held bus
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (vis) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= scan_addr;
        end else if (accept) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // Delay the scan flag so it lines up with the memory's read data
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= scan_issued;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // Per-frame accepted-write count, snapshotted at the start of vertical blanking
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            wr_cnt        <= '0;
            wr_count_last <= '0;
        end else if (v_rise) begin
            wr_count_last <= wr_cnt_next;
            wr_cnt        <= accept ? CNT_W'(1) : '0;
        end else begin
            wr_cnt <= wr_cnt_next;
        end
    end

    // Saturating count of cycles where the host was held off
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (clear_stats) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// tb/tb_pixel_mem_arbiter.sv - self-checking bench for pixel_mem_arbiter
module tb_pixel_mem_arbiter;

    localparam int AW = 19;
    localparam int PW = 4;
    localparam int CW = 16;

    logic          clk_in;
    logic          resetn;
    logic          h_blank;
    logic          v_blank;
    logic [AW-1:0] scan_addr;
    logic          vblank_only;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata;
    logic [PW-1:0] pix_out;
    logic          pix_valid;
    logic          frame_start;
    logic          clear_stats;
    logic [CW-1:0] wr_count_last;
    logic [CW-1:0] stall_cnt;

    int checks;
    int failures;

    pixel_mem_arbiter #(
        .IMG_W(640), .IMG_H(480), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(1), .CNT_W(CW)
    ) dut (
        .clk_in(clk_in), .resetn(resetn), .h_blank(h_blank), .v_blank(v_blank),
        .scan_addr(scan_addr), .vblank_only(vblank_only), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_out(pix_out), .pix_valid(pix_valid), .frame_start(frame_start),
        .clear_stats(clear_stats), .wr_count_last(wr_count_last), .stall_cnt(stall_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Single-port BRAM with one cycle of read latency
    logic [PW-1:0] bram [2048];
    logic [PW-1:0] bram_rd;
    initial begin
        for (int i = 0; i < 2048; i++) bram[i] = '0;
        bram_rd = '0;
    end
    always @(posedge clk_in) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr[10:0]] <= mem_wdata;
            else        bram_rd <= bram[mem_addr[10:0]];
        end
    end
    assign mem_rdata = bram_rd;

    typedef struct {
        logic          hb;
        logic          vb;
        logic          wv;
        logic [AW-1:0] wa;
        logic [PW-1:0] wd;
        logic [AW-1:0] sa;
        logic          exp_ready;
        logic          exp_en;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [PW-1:0] exp_wdata;
        logic          exp_pv;
        logic [PW-1:0] exp_pix;
        logic          exp_fs;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic hb, input logic vb, input logic wv,
                          input logic [AW-1:0] wa, input logic [PW-1:0] wd,
                          input logic [AW-1:0] sa);
        h_blank   = hb;
        v_blank   = vb;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        scan_addr = sa;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Reference model state for the randomized phase
    logic [PW-1:0] ref_mem [64];
    logic          m_prev, m_mode, m_fs, pv_hold;
    logic [PW-1:0] pd_hold;
    int            m_cnt, m_last, m_stall;

    int            s0, nready;
    logic          hb_r, vb_r, wv_r, allow_r, vis_r, acc_r, n_en, n_we, n_pv;
    logic [AW-1:0] wa_r, sa_r, n_addr;
    logic [PW-1:0] wd_r, n_pd;
    int            px, py;

    initial begin
        checks   = 0;
        failures = 0;

        // hb vb wv  wa   wd  sa  | rdy en we addr wdata pv pix fs
        tbl[0] = '{1'b0, 1'b1, 1'b1, 19'd5,   4'hA, 19'd0,   1'b1, 1'b1, 1'b1, 19'd5,   4'hA, 1'b0, 4'h0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 19'd100, 4'h7, 19'd0,   1'b1, 1'b1, 1'b1, 19'd100, 4'h7, 1'b0, 4'h0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 19'd0,   4'h0, 19'd0,   1'b1, 1'b0, 1'b0, 19'd100, 4'h7, 1'b0, 4'h0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 19'd6,   4'h3, 19'd0,   1'b1, 1'b1, 1'b1, 19'd6,   4'h3, 1'b0, 4'h0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 19'd9,   4'hF, 19'd100, 1'b0, 1'b1, 1'b0, 19'd100, 4'h3, 1'b0, 4'h0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 19'd0,   4'h0, 19'd42,  1'b0, 1'b1, 1'b0, 19'd42,  4'h3, 1'b1, 4'h7, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 19'd0,   4'h0, 19'd0,   1'b1, 1'b0, 1'b0, 19'd42,  4'h3, 1'b1, 4'h0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 19'd7,   4'h1, 19'd0,   1'b1, 1'b1, 1'b1, 19'd7,   4'h1, 1'b0, 4'h0, 1'b0};

        resetn      = 1'b0;
        vblank_only = 1'b0;
        clear_stats = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, '0, '0, '0);
        repeat (3) tick();

        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_out", pix_out, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_wr_count_last", wr_count_last, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].hb, tbl[i].vb, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].sa);
            #1;
            chk($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].exp_ready);
            tick();
            chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].exp_en);
            chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].exp_we);
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].exp_wdata);
            chk($sformatf("tbl%0d_pix_valid", i), pix_valid, tbl[i].exp_pv);
            chk($sformatf("tbl%0d_pix_out", i), pix_out, tbl[i].exp_pix);
            chk($sformatf("tbl%0d_frame_start", i), frame_start, tbl[i].exp_fs);
        end
        chk("tbl_stall_cnt", stall_cnt, 1);

        // Tear-free mode latched at v_blank rise blocks h-blank writes for the whole frame
        set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        vblank_only = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, '0, '0, '0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        s0     = int'(stall_cnt);
        nready = 0;
        for (int i = 0; i < 160; i++) begin
            if (i == 80) vblank_only = 1'b0;
            set_in(1'b1, 1'b0, 1'b1, 19'd300, 4'h5, '0);
            #1;
            if (wr_ready) nready++;
            tick();
        end
        chk("tearfree_ready_cycles", nready, 0);
        chk("tearfree_stall_delta", int'(stall_cnt) - s0, 160);
        chk("tearfree_no_write", mem_en, 0);
        set_in(1'b0, 1'b1, 1'b0, '0, '0, '0);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 19'd301, 4'h5, '0);
        #1;
        chk("mode_cleared_ready", wr_ready, 1);
        tick();

        // Per-frame write statistics
        set_in(1'b0, 1'b1, 1'b0, '0, '0, '0);
        tick();
        for (int i = 0; i < 37; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 19'(200 + i), 4'(i), '0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, '0, '0, '0);
        tick();
        chk("wr_count_last_37", wr_count_last, 37);
        set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, '0, '0, '0);
        tick();
        chk("wr_count_last_0", wr_count_last, 0);

        // frame_start pulse width, then stall saturation and clear
        set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("frame_start_high", frame_start, 1);
        tick();
        chk("frame_start_one_cycle", frame_start, 0);
        set_in(1'b0, 1'b0, 1'b1, 19'd5, 4'h1, '0);
        repeat (70000) tick();
        chk("stall_saturated", stall_cnt, 16'hFFFF);
        clear_stats = 1'b1;
        tick();
        chk("stall_cleared", stall_cnt, 0);
        clear_stats = 1'b0;

        // Reset asserted with the scan pipeline full
        set_in(1'b0, 1'b0, 1'b0, '0, '0, 19'd100);
        repeat (3) tick();
        chk("pre_reset_pix_valid", pix_valid, 1);
        chk("pre_reset_pix_out", pix_out, 4'h7);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_pix_valid", pix_valid, 0);
        chk("async_rst_pix_out", pix_out, 0);
        chk("async_rst_mem_en", mem_en, 0);
        chk("async_rst_frame_start", frame_start, 0);
        set_in(1'b0, 1'b1, 1'b1, 19'd9, 4'h9, '0);
        tick();
        chk("in_rst_mem_en", mem_en, 0);
        tick();
        chk("in_rst_mem_we", mem_we, 0);
        set_in(1'b0, 1'b1, 1'b0, '0, '0, '0);
        resetn = 1'b1;

        // Randomized frames against the behavioural model
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        m_prev  = 1'b1;
        m_mode  = 1'b0;
        m_fs    = 1'b0;
        m_cnt   = 0;
        m_last  = 0;
        m_stall = 0;
        pv_hold = 1'b0;
        pd_hold = '0;
        px      = 0;
        py      = 7;
        for (int c = 0; c < 3000; c++) begin
            hb_r = (px >= 14);
            vb_r = (py >= 7);
            wv_r = ($urandom_range(0, 2) != 0);
            wa_r = 19'(1000 + $urandom_range(0, 63));
            wd_r = 4'($urandom_range(0, 15));
            sa_r = 19'(1000 + $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) vblank_only = ~vblank_only;
            clear_stats = ($urandom_range(0, 99) == 0);
            set_in(hb_r, vb_r, wv_r, wa_r, wd_r, sa_r);
            #1;

            allow_r = vb_r | (hb_r & ~m_mode);
            vis_r   = ~hb_r & ~vb_r;
            acc_r   = wv_r & allow_r;
            chk("rnd_wr_ready", wr_ready, allow_r);

            n_pv   = vis_r;
            n_pd   = vis_r ? ref_mem[sa_r - 19'd1000] : '0;
            n_en   = vis_r | acc_r;
            n_we   = ~vis_r & acc_r;
            n_addr = vis_r ? sa_r : wa_r;
            if (acc_r) ref_mem[wa_r - 19'd1000] = wd_r;

            if (vb_r && !m_prev) begin
                m_last = (m_cnt + (acc_r ? 1 : 0) > 65535) ? 65535 : m_cnt + (acc_r ? 1 : 0);
                m_cnt  = acc_r ? 1 : 0;
                m_mode = vblank_only;
            end else if (acc_r && m_cnt < 65535) begin
                m_cnt++;
            end
            if (clear_stats) m_stall = 0;
            else if (wv_r && !allow_r && m_stall < 65535) m_stall++;
            m_fs   = ~vb_r & m_prev;
            m_prev = vb_r;

            tick();
            chk("rnd_pix_valid", pix_valid, pv_hold);
            chk("rnd_pix_out", pix_out, pd_hold);
            pv_hold = n_pv;
            pd_hold = n_pd;
            chk("rnd_mem_en", mem_en, n_en);
            chk("rnd_mem_we", mem_we, n_we);
            if (n_en) chk("rnd_mem_addr", mem_addr, n_addr);
            if (n_we) chk("rnd_mem_wdata", mem_wdata, wd_r);
            chk("rnd_frame_start", frame_start, m_fs);
            chk("rnd_wr_count_last", wr_count_last, m_last);
            chk("rnd_stall_cnt", stall_cnt, m_stall);

            px++;
            if (px == 20) begin
                px = 0;
                py = (py == 9) ? 0 : py + 1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_mem_arbiter.md
Name: pixel_mem_arbiter

Overview:
- Shares one single-port pixel frame buffer (BRAM) between video scanout and a host write port.
- Scanout owns the memory during visible cycles. Host writes are accepted only in blanking windows.
- An optional tear-free mode restricts writes to vertical blanking. The mode is latched per frame.
- Sits between the hsync/vsync timing blocks and the frame-buffer memory. Returns scanout pixels with a fixed, known latency plus per-frame write statistics.

Parameters:
IMG_W, 640, image width in pixels
IMG_H, 480, image height in lines
PIX_W, 4, pixel data width
ADDR_W, $clog2(IMG_W*IMG_H) (=19), memory address width
RD_LAT, 1, memory read latency in cycles from mem_en to mem_rdata (1..4)
CNT_W, 16, width of statistics counters

Ports:
clk_in  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
h_blank  in  1  horizontal blanking from hsync
v_blank  in  1  vertical blanking from vsync
scan_addr  in  ADDR_W  scanout read address, valid when both blanks are low
vblank_only  in  1  tear-free mode request; sampled only at v_blank rising edge
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle (combinational)
wr_addr  in  ADDR_W  host write address
wr_data  in  PIX_W  host write data
mem_en  out  1  memory enable (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  PIX_W  memory write data (registered)
mem_rdata  in  PIX_W  memory read data, RD_LAT cycles after mem_en
pix_out  out  PIX_W  scanout pixel; 0 when pix_valid low
pix_valid  out  1  pix_out carries scanout data
frame_start  out  1  one-cycle pulse on v_blank falling edge
clear_stats  in  1  synchronous clear of stall_cnt
wr_count_last  out  CNT_W  accepted writes during the previous frame
stall_cnt  out  CNT_W  cycles with wr_valid & ~wr_ready, saturating

Behaviour:
- Reset: all outputs 0; state=VBL; mode_latched=0; prev v_blank=1; internal counters 0.
- FSM is updated every cycle from inputs: VIS (h_blank=0, v_blank=0), HBL (h_blank=1, v_blank=0), VBL (v_blank=1, overrides h_blank).
- Write permission is combinational on the current cycle. allow = v_blank | (h_blank & ~mode_latched). wr_ready = allow.
- Arbitration, registered into the mem_* outputs on the next edge:
  - If VIS: mem_en=1, mem_we=0, mem_addr=scan_addr. The scan flag is issued.
  - Else if wr_valid & allow: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Else: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their values.
- Scanout always wins. Host and scanout never both drive the memory in the same cycle, because allow=0 whenever VIS.
- Pixel return:
  - The scan flag passes through an RD_LAT-deep shift register aligned with mem_rdata.
  - pix_valid = delayed flag. pix_out = mem_rdata when pix_valid, else 0.
  - Total latency from scan_addr to pix_out = 1+RD_LAT cycles.
- mode_latched: loaded from vblank_only on the v_blank rising edge (VIS/HBL->VBL). Changes of vblank_only at any other time have no effect until the next frame.
- frame_start: asserted for one cycle in the first cycle where v_blank=0 after v_blank=1 (based on a registered copy of v_blank).
- wr_count:
  - The internal counter increments on each accepted write (wr_valid & wr_ready).
  - On the v_blank rising edge, wr_count_last takes the counter value, including any write accepted in that same cycle. The counter restarts at 0, or at 1 if a write is accepted in that cycle.
  - The counter saturates at 2^CNT_W-1.
- stall_cnt: increments when wr_valid & ~wr_ready and saturates at 2^CNT_W-1. If clear_stats is high, it is set to 0, taking priority over the increment.
- Reset mid-operation: pending pipeline flags are cleared, so pix_valid drops immediately and no memory write is issued after reset assertion.
- Host data is not buffered. The host must hold wr_valid/wr_addr/wr_data until it sees wr_ready in the same cycle.

Test Plan:
1. Reset released during VBL with vblank_only=0, wr_valid=1, wr_addr=5, wr_data=0xA -> wr_ready=1; next cycle mem_en=1, mem_we=1, mem_addr=5, mem_wdata=0xA.
2. VIS cycle with scan_addr=100 and concurrent wr_valid=1 -> wr_ready=0; next cycle mem_en=1, mem_we=0, mem_addr=100; with RD_LAT=1 and mem_rdata=0x7, pix_out=0x7 and pix_valid=1 two cycles after scan_addr was presented; stall_cnt increments by 1.
3. vblank_only=1 at v_blank rise, then a 160-cycle HBL window with continuous wr_valid -> wr_ready=0 throughout and stall_cnt=+160. Set vblank_only=0 mid-frame -> still blocked until the next v_blank rise.
4. Exactly 37 accepted writes in one frame -> at the next v_blank rise, wr_count_last=37; the following frame with 0 writes gives wr_count_last=0.
5. v_blank 1->0 -> frame_start high for exactly 1 cycle. Hold wr_valid with ~wr_ready for 70000 cycles -> stall_cnt=0xFFFF, then clear_stats -> 0.
6. Assert resetn=0 during VIS with the scan pipeline full -> pix_valid, pix_out, mem_en and frame_start all 0 immediately; no write is issued.
